sync_fifo_tmr: RTL and testbench

Parametrised single-clock FIFO with triple-modular-redundant (TMR) pointers and occupancy counter, sitting between the UART byte engines and the host-side register interface. It generalises the existing byte FIFO: arbitrary width and power-of-two depth, a full-range occupancy count, a selectable overflow policy (drop-new or overwrite-oldest), sticky overflow and underflow flags, and an SEU-correction indicator.

---
 rtl/sync_fifo_tmr_if.sv | 32 +++
 rtl/sync_fifo_tmr.sv | 111 +++++++++++
 tb/tb_sync_fifo_tmr.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_tmr_if.sv
// Handshake and status bundle between the TMR FIFO and its producer/consumer.
// The testbench or the host side uses master; the FIFO uses slave.
interface sync_fifo_tmr_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CW         = 5
);
    logic [DATA_WIDTH-1:0] data_i;
    logic                  n_we_i;
    logic                  n_re_i;
    logic                  n_clr_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  rd_valid_o;
    logic [CW-1:0]         count_o;
    logic                  p_empty_o;
    logic                  p_full_o;
    logic                  p_nearfull_o;
    logic                  p_over_o;
    logic                  p_under_o;
    logic                  seu_corr_o;

    modport master (
        output data_i, n_we_i, n_re_i, n_clr_i,
        input  data_o, rd_valid_o, count_o, p_empty_o, p_full_o, p_nearfull_o,
               p_over_o, p_under_o, seu_corr_o
    );

    modport slave (
        input  data_i, n_we_i, n_re_i, n_clr_i,
        output data_o, rd_valid_o, count_o, p_empty_o, p_full_o, p_nearfull_o,
               p_over_o, p_under_o, seu_corr_o
    );
endinterface

// File: rtl/sync_fifo_tmr.sv
// Single-clock FIFO whose pointers and occupancy count are held in three voted,
// self-scrubbing copies; optional overwrite-oldest policy when full.
module sync_fifo_tmr #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned NEAR_FULL_LEVEL = (DEPTH / 4) * 3,
    parameter int unsigned OVERWRITE       = 0
) (
    input  logic           clk,
    input  logic           rst,
    sync_fifo_tmr_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_a, wr_b, wr_c;
    logic [AW-1:0] rd_a, rd_b, rd_c;
    logic [CW-1:0] cnt_a, cnt_b, cnt_c;

    logic [AW-1:0] wr_v, rd_v, wr_n, rd_n;
    logic [CW-1:0] cnt_v, cnt_n;
    logic          seu_det, full_now, rd_acc, wr_acc, ovw, over_set, under_set;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  rd_valid_q, empty_q, full_q, nearfull_q;
    logic                  over_q, under_q, seu_q;

    // Vote, acceptance and next-state; decisions depend only on the voted count.
    always_comb begin
        wr_v  = (wr_a & wr_b) | (wr_a & wr_c) | (wr_b & wr_c);
        rd_v  = (rd_a & rd_b) | (rd_a & rd_c) | (rd_b & rd_c);
        cnt_v = (cnt_a & cnt_b) | (cnt_a & cnt_c) | (cnt_b & cnt_c);

        seu_det = (wr_a != wr_v) || (wr_b != wr_v) || (wr_c != wr_v) ||
                  (rd_a != rd_v) || (rd_b != rd_v) || (rd_c != rd_v) ||
                  (cnt_a != cnt_v) || (cnt_b != cnt_v) || (cnt_c != cnt_v);

        full_now  = (cnt_v == CW'(DEPTH));
        rd_acc    = !bus.n_re_i && (cnt_v != '0);
        wr_acc    = !bus.n_we_i && (!full_now || rd_acc || (OVERWRITE != 0));
        ovw       = wr_acc && full_now && !rd_acc;
        over_set  = !bus.n_we_i && full_now && !rd_acc;
        under_set = !bus.n_re_i && (cnt_v == '0);

        wr_n  = wr_v + AW'(wr_acc);
        rd_n  = rd_v + AW'(rd_acc || ovw);
        cnt_n = cnt_v + CW'(wr_acc && !ovw) - CW'(rd_acc);
    end

    // Control state; every copy is rewritten from the voted value each cycle.
    always_ff @(posedge clk) begin
        if (!rst || !bus.n_clr_i) begin
            wr_a       <= '0;
            wr_b       <= '0;
            wr_c       <= '0;
            rd_a       <= '0;
            rd_b       <= '0;
            rd_c       <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            cnt_c      <= '0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            nearfull_q <= 1'b0;
            over_q     <= 1'b0;
            under_q    <= 1'b0;
            seu_q      <= 1'b0;
        end else begin
            wr_a       <= wr_n;
            wr_b       <= wr_n;
            wr_c       <= wr_n;
            rd_a       <= rd_n;
            rd_b       <= rd_n;
            rd_c       <= rd_n;
            cnt_a      <= cnt_n;
            cnt_b      <= cnt_n;
            cnt_c      <= cnt_n;
            if (rd_acc) begin
                data_q <= mem[rd_v];
            end
            rd_valid_q <= rd_acc;
            empty_q    <= (cnt_n == '0);
            full_q     <= (cnt_n == CW'(DEPTH));
            nearfull_q <= (cnt_n >= CW'(NEAR_FULL_LEVEL));
            over_q     <= over_q | over_set;
            under_q    <= under_q | under_set;
            seu_q      <= seu_det;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (rst && bus.n_clr_i && wr_acc) begin
            mem[wr_v] <= bus.data_i;
        end
    end

    assign bus.data_o       = data_q;
    assign bus.rd_valid_o   = rd_valid_q;
    assign bus.count_o      = cnt_a;
    assign bus.p_empty_o    = empty_q;
    assign bus.p_full_o     = full_q;
    assign bus.p_nearfull_o = nearfull_q;
    assign bus.p_over_o     = over_q;
    assign bus.p_under_o    = under_q;
    assign bus.seu_corr_o   = seu_q;
endmodule

// File: tb/tb_sync_fifo_tmr.sv
// Directed bench: a drop-new and an overwrite instance share one stimulus stream,
// driven from a vector table, followed by pointer-wrap and SEU sequences.
module tb_sync_fifo_tmr;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       n_we, n_re, n_clr;

    int unsigned checks = 0;
    int unsigned errors = 0;

    sync_fifo_tmr_if #(.DATA_WIDTH(8), .CW(5)) b0 ();
    sync_fifo_tmr_if #(.DATA_WIDTH(8), .CW(5)) b1 ();

    assign b0.data_i  = data;
    assign b0.n_we_i  = n_we;
    assign b0.n_re_i  = n_re;
    assign b0.n_clr_i = n_clr;
    assign b1.data_i  = data;
    assign b1.n_we_i  = n_we;
    assign b1.n_re_i  = n_re;
    assign b1.n_clr_i = n_clr;

    sync_fifo_tmr #(.DATA_WIDTH(8), .DEPTH(16), .NEAR_FULL_LEVEL(12), .OVERWRITE(0))
        u0 (.clk(clk), .rst(rst), .bus(b0));
    sync_fifo_tmr #(.DATA_WIDTH(8), .DEPTH(16), .NEAR_FULL_LEVEL(12), .OVERWRITE(1))
        u1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       rst, clr, we, re;
        logic [7:0] din;
        logic [4:0] cnt;
        logic [7:0] dout, dout1;
        logic       rv, ov, un;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic r, input logic c, input logic w, input logic rd,
                                input logic [7:0] din, input logic [4:0] cnt,
                                input logic [7:0] dout, input logic [7:0] dout1,
                                input logic rv, input logic ov, input logic un);
        vec_t v;
        v.rst = r; v.clr = c; v.we = w; v.re = rd; v.din = din; v.cnt = cnt;
        v.dout = dout; v.dout1 = dout1; v.rv = rv; v.ov = ov; v.un = un;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic rd, input logic [7:0] din);
        @(negedge clk);
        rst = 1'b1; n_clr = 1'b1; n_we = !w; n_re = !rd; data = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; n_clr = 1'b1; n_we = 1'b1; n_re = 1'b1; data = '0;

        // reset
        add(1, 0, 0, 0, 8'h00, 5'd0, 8'h00, 8'h00, 0, 0, 0);
        // fill 0x00..0x0F
        for (int i = 0; i < 16; i++)
            add(0, 0, 1, 0, 8'(i), 5'(i + 1), 8'h00, 8'h00, 0, 0, 0);
        // write while full: u0 drops, u1 overwrites oldest
        add(0, 0, 1, 0, 8'hAA, 5'd16, 8'h00, 8'h00, 0, 1, 0);
        for (int k = 0; k < 16; k++)
            add(0, 0, 0, 1, 8'h00, 5'(15 - k), 8'(k), (k < 15) ? 8'(k + 1) : 8'hAA, 1, 1, 0);
        add(0, 0, 0, 0, 8'h00, 5'd0, 8'h0F, 8'hAA, 0, 1, 0);
        add(0, 1, 0, 0, 8'h00, 5'd0, 8'h00, 8'h00, 0, 0, 0);
        // full with simultaneous read+write
        for (int i = 0; i < 16; i++)
            add(0, 0, 1, 0, 8'(i), 5'(i + 1), 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 1, 1, 8'h55, 5'd16, 8'h00, 8'h00, 1, 0, 0);
        for (int k = 1; k <= 16; k++)
            add(0, 0, 0, 1, 8'h00, 5'(16 - k), (k < 16) ? 8'(k) : 8'h55,
                (k < 16) ? 8'(k) : 8'h55, 1, 0, 0);
        // empty with simultaneous read+write: write only, underflow flagged
        add(0, 0, 1, 1, 8'h77, 5'd1, 8'h55, 8'h55, 0, 0, 1);
        add(0, 0, 0, 1, 8'h00, 5'd0, 8'h77, 8'h77, 1, 0, 1);
        add(0, 1, 0, 0, 8'h00, 5'd0, 8'h00, 8'h00, 0, 0, 0);
        // clear with 7 stored and a read in flight
        add(0, 0, 0, 1, 8'h00, 5'd0, 8'h00, 8'h00, 0, 0, 1);
        for (int i = 0; i < 7; i++)
            add(0, 0, 1, 0, 8'(8'hC0 + i), 5'(i + 1), 8'h00, 8'h00, 0, 0, 1);
        add(0, 0, 0, 1, 8'h00, 5'd6, 8'hC0, 8'hC0, 1, 0, 1);
        add(0, 1, 1, 1, 8'hEE, 5'd0, 8'h00, 8'h00, 0, 0, 0);
        // same again with rst
        add(0, 0, 0, 1, 8'h00, 5'd0, 8'h00, 8'h00, 0, 0, 1);
        for (int i = 0; i < 7; i++)
            add(0, 0, 1, 0, 8'(8'hC0 + i), 5'(i + 1), 8'h00, 8'h00, 0, 0, 1);
        add(0, 0, 0, 1, 8'h00, 5'd6, 8'hC0, 8'hC0, 1, 0, 1);
        add(1, 0, 1, 1, 8'hEE, 5'd0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 0, 0, 8'h00, 5'd0, 8'h00, 8'h00, 0, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = !vq[i].rst; n_clr = !vq[i].clr; n_we = !vq[i].we; n_re = !vq[i].re;
            data = vq[i].din;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d count", i), 32'(b0.count_o), 32'(vq[i].cnt));
            chk($sformatf("v%0d data", i), 32'(b0.data_o), 32'(vq[i].dout));
            chk($sformatf("v%0d rd_valid", i), 32'(b0.rd_valid_o), 32'(vq[i].rv));
            chk($sformatf("v%0d empty", i), 32'(b0.p_empty_o), 32'(vq[i].cnt == 5'd0));
            chk($sformatf("v%0d full", i), 32'(b0.p_full_o), 32'(vq[i].cnt == 5'd16));
            chk($sformatf("v%0d nearfull", i), 32'(b0.p_nearfull_o), 32'(vq[i].cnt >= 5'd12));
            chk($sformatf("v%0d over", i), 32'(b0.p_over_o), 32'(vq[i].ov));
            chk($sformatf("v%0d under", i), 32'(b0.p_under_o), 32'(vq[i].un));
            chk($sformatf("v%0d seu", i), 32'(b0.seu_corr_o), 32'd0);
            chk($sformatf("v%0d ow data", i), 32'(b1.data_o), 32'(vq[i].dout1));
            chk($sformatf("v%0d ow count", i), 32'(b1.count_o), 32'(vq[i].cnt));
            chk($sformatf("v%0d ow over", i), 32'(b1.p_over_o), 32'(vq[i].ov));
        end

        // 40 write/read pairs wrap the pointers twice and more
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 8'(i * 3 + 1));
            chk($sformatf("pair%0d count after write", i), 32'(b0.count_o), 32'd1);
            step(0, 1, 8'h00);
            chk($sformatf("pair%0d data", i), 32'(b0.data_o), 32'(8'(i * 3 + 1)));
            chk($sformatf("pair%0d rd_valid", i), 32'(b0.rd_valid_o), 32'd1);
            chk($sformatf("pair%0d count after read", i), 32'(b0.count_o), 32'd0);
        end

        // single-copy upset on wr_ptr (voted value is 11 here)
        step(1, 0, 8'hA1);
        step(1, 0, 8'hA2);
        step(1, 0, 8'hA3);
        @(negedge clk);
        n_we = 1'b1; n_re = 1'b1;
        force u0.wr_b = 4'd5;
        @(posedge clk);
        #1;
        chk("seu pulse", 32'(b0.seu_corr_o), 32'd1);
        chk("seu count", 32'(b0.count_o), 32'd3);
        force u0.wr_b = 4'd11;
        release u0.wr_b;
        step(0, 0, 8'h00);
        chk("seu pulse once", 32'(b0.seu_corr_o), 32'd0);
        step(0, 1, 8'h00);
        chk("seu data0", 32'(b0.data_o), 32'hA1);
        step(0, 1, 8'h00);
        chk("seu data1", 32'(b0.data_o), 32'hA2);
        step(0, 1, 8'h00);
        chk("seu data2", 32'(b0.data_o), 32'hA3);
        chk("seu empty", 32'(b0.p_empty_o), 32'd1);
        step(1, 0, 8'hB5);
        step(0, 1, 8'h00);
        chk("seu wr_ptr intact", 32'(b0.data_o), 32'hB5);
        chk("seu no further pulse", 32'(b0.seu_corr_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
